// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU with valid/ready intake, bit-serial shifts and a held result/flag output.
// Optional macro ALU_MUL_EN enables a shift-add multiply on op 4'b1000 (illegal opcode otherwise).
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err,
  output logic             busy
);
  localparam int AMT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR  = 4'b0011,
    OP_SHL = 4'b0100, OP_SHR = 4'b0101, OP_XOR = 4'b0110, OP_SRA = 4'b0111,
    OP_MUL = 4'b1000
  } op_e;

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] opnd;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] cnt_init;
  logic             c_work;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] res_next;
  logic             c_next;
  logic             v_next;
  logic             err_next;
`ifdef ALU_MUL_EN
  // Multiply: work holds the multiplier (low product half), hi accumulates the high half.
  logic [WIDTH-1:0] hi;
  logic [WIDTH:0]   mac;
  assign mac = {1'b0, hi} + (work[0] ? {1'b0, opnd} : '0);
`endif

  always_comb begin
    cnt_init = '0;
    if (op == OP_SHL || op == OP_SHR || op == OP_SRA)
      cnt_init = (b >= WIDTH'(WIDTH)) ? AMT_W'(WIDTH) : b[AMT_W-1:0];
`ifdef ALU_MUL_EN
    if (op == OP_MUL)
      cnt_init = AMT_W'(WIDTH);
`endif
  end

  assign add_sum = {1'b0, work} + {1'b0, opnd};
  assign sub_sum = {1'b0, work} + {1'b0, ~opnd} + (WIDTH+1)'(1);

  always_comb begin
    res_next = '0;
    c_next   = 1'b0;
    v_next   = 1'b0;
    err_next = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_next = add_sum[WIDTH-1:0];
        c_next   = add_sum[WIDTH];
        v_next   = (work[WIDTH-1] == opnd[WIDTH-1]) && (add_sum[WIDTH-1] != work[WIDTH-1]);
      end
      OP_SUB: begin
        res_next = sub_sum[WIDTH-1:0];
        c_next   = sub_sum[WIDTH];
        v_next   = (work[WIDTH-1] != opnd[WIDTH-1]) && (sub_sum[WIDTH-1] != work[WIDTH-1]);
      end
      OP_AND: res_next = work & opnd;
      OP_OR:  res_next = work | opnd;
      OP_XOR: res_next = work ^ opnd;
      OP_SHL, OP_SHR, OP_SRA: begin
        res_next = work;
        c_next   = c_work;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        res_next = work;
        c_next   = |hi;
      end
`endif
      default: err_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
      op_q      <= OP_ADD;
      work      <= '0;
      opnd      <= '0;
      cnt       <= '0;
      c_work    <= 1'b0;
`ifdef ALU_MUL_EN
      hi        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op_e'(op);
            work     <= a;
            opnd     <= b;
            cnt      <= cnt_init;
            c_work   <= 1'b0;
            err      <= 1'b0;
`ifdef ALU_MUL_EN
            hi       <= '0;
`endif
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - AMT_W'(1);
            case (op_q)
              OP_SHL: begin
                c_work <= work[WIDTH-1];
                work   <= {work[WIDTH-2:0], 1'b0};
              end
              OP_SHR: begin
                c_work <= work[0];
                work   <= {1'b0, work[WIDTH-1:1]};
              end
              OP_SRA: begin
                c_work <= work[0];
                work   <= {work[WIDTH-1], work[WIDTH-1:1]};
              end
`ifdef ALU_MUL_EN
              OP_MUL: begin
                hi   <= mac[WIDTH:1];
                work <= {mac[0], work[WIDTH-1:1]};
              end
`endif
              default: ;
            endcase
          end else begin
            result    <= res_next;
            flag_z    <= (res_next == '0);
            flag_n    <= res_next[WIDTH-1];
            flag_c    <= c_next;
            flag_v    <= v_next;
            err       <= err_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=8): scoreboard of model results, compared when out_valid rises.
module tb_alu_seq_core;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         e;
  } flags_t;

  typedef struct packed {
    flags_t f;
    int     lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_c, flag_v, err, busy;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .err(err), .busy(busy)
  );

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] opv);
    exp_t               e;
    logic [8:0]         s;
    logic [15:0]        t;
    logic signed [15:0] ts;
    int                 amt;
    e     = '0;
    e.lat = 1;
    amt   = (bv > 8) ? 8 : int'(bv);
    case (opv)
      4'h0: begin
        s = {1'b0, av} + {1'b0, bv};
        e.f.res = s[7:0];
        e.f.c = s[8];
        e.f.v = (av[7] == bv[7]) && (s[7] != av[7]);
      end
      4'h1: begin
        e.f.res = av - bv;
        e.f.c = (av >= bv);
        e.f.v = (av[7] != bv[7]) && (e.f.res[7] != av[7]);
      end
      4'h2: e.f.res = av & bv;
      4'h3: e.f.res = av | bv;
      4'h6: e.f.res = av ^ bv;
      4'h4: begin
        t = {8'h00, av} << amt;
        e.f.res = t[7:0];
        e.f.c = t[8];
        e.lat = amt + 1;
      end
      4'h5: begin
        t = {av, 8'h00} >> amt;
        e.f.res = t[15:8];
        e.f.c = t[7];
        e.lat = amt + 1;
      end
      4'h7: begin
        ts = {av, 8'h00};
        t = ts >>> amt;
        e.f.res = t[15:8];
        e.f.c = t[7];
        e.lat = amt + 1;
      end
`ifdef ALU_MUL_EN
      4'h8: begin
        t = {8'h00, av} * {8'h00, bv};
        e.f.res = t[7:0];
        e.f.c = |t[15:8];
        e.lat = 9;
      end
`endif
      default: e.f.e = 1'b1;
    endcase
    e.f.z = (e.f.res == 8'h00);
    e.f.n = e.f.res[7];
    return e;
  endfunction

  function automatic flags_t observed();
    observed = {result, flag_z, flag_n, flag_c, flag_v, err};
  endfunction

  // Drive one operation (bounded wait for in_ready) and push its expectation.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] opv);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready got in_ready=%b exp=1", in_ready);
    end
    a = av; b = bv; op = opv; in_valid = 1'b1;
    sb.push_back(model(av, bv, opv));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
  endtask

  // Count cycles from the accept edge until out_valid; also report whether busy stayed high.
  task automatic wait_out(output int lat, output logic busy_all);
    lat = 0;
    busy_all = 1'b1;
    while (!out_valid && lat < 100) begin
      if (busy !== 1'b1) busy_all = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({result, flag_z, flag_n, flag_c, flag_v, err, out_valid, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {result, flag_z, flag_n, flag_c, flag_v, err, out_valid, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_arith();
    logic [3:0] ops [10] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h6, 4'h6, 4'h9, 4'h0};
    logic [7:0] as  [10] = '{8'hF0, 8'h7F, 8'h50, 8'h33, 8'hF0, 8'hA0, 8'hFF, 8'h5A, 8'h12, 8'h80};
    logic [7:0] bs  [10] = '{8'h20, 8'h01, 8'h70, 8'h33, 8'h3C, 8'h05, 8'h0F, 8'h5A, 8'h34, 8'h80};
    exp_t e;
    int   lat;
    logic ball;
    for (int i = 0; i < 10; i++) begin
      send(as[i], bs[i], ops[i]);
      wait_out(lat, ball);
      e = sb.pop_front();
      checks++;
      if (observed() !== e.f) begin
        failures++;
        $display("FAIL arith_%0d got=%h exp=%h", i, observed(), e.f);
      end
      checks++;
      if (lat !== e.lat) begin
        failures++;
        $display("FAIL arith_lat_%0d got=%0d exp=%0d", i, lat, e.lat);
      end
      if (i == 0) begin
        checks++;
        if ({result, flag_c, flag_z, flag_n, flag_v} !== {8'h10, 4'b1000}) begin
          failures++;
          $display("FAIL add_f0_20 got=%h exp=%h", {result, flag_c, flag_z, flag_n, flag_v}, {8'h10, 4'b1000});
        end
      end
      release_out();
    end
  endtask

  task automatic test_shift();
    logic [3:0] ops [8] = '{4'h4, 4'h7, 4'h5, 4'h4, 4'h5, 4'h7, 4'h5, 4'h4};
    logic [7:0] as  [8] = '{8'h81, 8'h80, 8'hF0, 8'hFF, 8'hA5, 8'h4C, 8'h81, 8'h01};
    logic [7:0] bs  [8] = '{8'h03, 8'd200, 8'h00, 8'h08, 8'h04, 8'h09, 8'h07, 8'h07};
    exp_t e;
    int   lat;
    logic ball;
    for (int i = 0; i < 8; i++) begin
      send(as[i], bs[i], ops[i]);
      wait_out(lat, ball);
      e = sb.pop_front();
      checks++;
      if (observed() !== e.f) begin
        failures++;
        $display("FAIL shift_%0d got=%h exp=%h", i, observed(), e.f);
      end
      checks++;
      if (lat !== e.lat) begin
        failures++;
        $display("FAIL shift_lat_%0d got=%0d exp=%0d", i, lat, e.lat);
      end
      checks++;
      if (ball !== 1'b1) begin
        failures++;
        $display("FAIL shift_busy_%0d got=%b exp=1", i, ball);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    exp_t   e;
    int     lat;
    logic   ball;
    logic   stable = 1'b1;
    flags_t snap;
    send(8'h7F, 8'h01, 4'h0);
    wait_out(lat, ball);
    snap = observed();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 4'h0;
      @(posedge clk); #1;
      if (observed() !== snap || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (observed() !== e.f) begin
      failures++;
      $display("FAIL bp_result got=%h exp=%h", observed(), e.f);
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold got=%b exp=1", stable);
    end
    release_out();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL bp_release got=%b exp=010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    logic ball;
    send(8'hFF, 8'h07, 4'h5);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if ({result, flag_z, flag_n, flag_c, flag_v, err, out_valid, busy} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0", {result, flag_z, flag_n, flag_c, flag_v, err, out_valid, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL midreset_idle got=%b exp=10", {in_ready, busy});
    end
    send(8'h01, 8'h01, 4'h0);
    wait_out(lat, ball);
    e = sb.pop_front();
    checks++;
    if (observed() !== e.f || result !== 8'h02) begin
      failures++;
      $display("FAIL midreset_add got=%h exp=%h", observed(), e.f);
    end
    release_out();
  endtask

  task automatic test_mul();
    logic [7:0] as [3] = '{8'h0F, 8'h10, 8'hFF};
    logic [7:0] bs [3] = '{8'h11, 8'h10, 8'hFF};
    exp_t e;
    int   lat;
    logic ball;
    for (int i = 0; i < 3; i++) begin
      send(as[i], bs[i], 4'h8);
      wait_out(lat, ball);
      e = sb.pop_front();
      checks++;
      if (observed() !== e.f) begin
        failures++;
        $display("FAIL mul_%0d got=%h exp=%h", i, observed(), e.f);
      end
      checks++;
      if (lat !== e.lat) begin
        failures++;
        $display("FAIL mul_lat_%0d got=%0d exp=%0d", i, lat, e.lat);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    logic ball;
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), 8'($urandom_range(0, 12)), 4'($urandom_range(0, 15)));
      wait_out(lat, ball);
      e = sb.pop_front();
      checks++;
      if (observed() !== e.f || lat !== e.lat) begin
        failures++;
        $display("FAIL b2b_%0d got=%h/%0d exp=%h/%0d", i, observed(), lat, e.f, e.lat);
      end
      release_out();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_backpressure();
    test_reset_mid();
    test_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised sequential ALU that replaces the fixed 8-bit combinational result mux, built around a small FSM. Operands and opcode are taken through a valid/ready handshake. Shifts run one bit per cycle by a variable amount taken from B. The registered result and Z/N/C/V flags are held under out_valid/out_ready backpressure. It sits between the operand registers and the accumulator/output-pin logic of the top-level ALU.

Parameters:
WIDTH, 8, datapath width in bits (legal range 4..32)
AMT_W, $clog2(WIDTH)+1, local parameter; width of the shift-amount counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and opcode valid
in_ready  output  1  block can accept; high only in IDLE
a  input  WIDTH  operand A
b  input  WIDTH  operand B; used as the shift amount for shift ops
op  input  4  opcode (see Behaviour)
out_valid  output  1  result and flags valid; high only in DONE
out_ready  input  1  consumer takes the result
result  output  WIDTH  registered result
flag_z  output  1  result == 0
flag_n  output  1  result[WIDTH-1]
flag_c  output  1  carry / no-borrow / last bit shifted out
flag_v  output  1  signed overflow
err  output  1  illegal opcode was executed
busy  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-shift): state=IDLE; result, all flags, err, out_valid and busy = 0; in_ready = 1 once rst_n deasserts. Any operation in flight is discarded.
- Opcodes: 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 SHL A, 0101 SHR A (logical), 0110 XOR, 0111 SRA A (arithmetic), 1000 MUL (optional feature only), all other codes illegal.
- FSM states: IDLE, EXEC, DONE.
- IDLE: when in_valid=1, a, b and op are latched at the clock edge and the FSM goes to EXEC.
  - For shift ops, cnt = min(b, WIDTH).
  - For all other ops, cnt = 0.
- EXEC:
  - While cnt != 0: shift the working register one bit per cycle. SHL fills with 0, SHR fills with 0, SRA fills with the sign bit. The bit shifted out goes into c_work, and cnt decrements.
  - When cnt == 0: result, flags and err are written and the FSM goes to DONE.
- Latency: out_valid rises 1+cnt cycles after the accept edge.
  - Non-shift ops: 1 cycle.
  - Shift ops: min(b, WIDTH)+1 cycles.
- DONE: out_valid=1. result and flags stay stable until a cycle with out_ready=1, then the FSM returns to IDLE. in_ready stays 0 in DONE, so there is no same-cycle accept.
- Arithmetic and flags:
  - ADD: {C, result} = A+B. V = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
  - SUB: result = A+~B+1; C = 1 when A>=B unsigned. V = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
  - AND/OR/XOR: C=0, V=0.
  - Shifts: C = last bit shifted out, or 0 when the amount is 0; V=0.
  - Shift amount >= WIDTH: result is all zeros for SHL/SHR, all sign bits for SRA; C = the last bit out after WIDTH steps.
  - Z and N are always derived from the final result.
- Illegal opcode: goes through EXEC in 1 cycle; result=0, Z=1, N=C=V=0, err=1. err clears on the next accepted op.
- Inputs a, b and op may change freely outside the accept edge; the block uses only the latched copies.

Optional Feature:
Macro ALU_MUL_EN.
- With the macro defined: op 1000 = unsigned shift-add multiply, keeping the low WIDTH bits of the product. cnt = WIDTH, one partial product per EXEC cycle, latency WIDTH+1. C = 1 if any discarded high product bit is 1; V=0; err=0.
- Without the macro: 1000 is an illegal opcode (err=1, result=0), and no multiplier logic is synthesised.

Test Plan:
- ADD a=0xF0 b=0x20 (WIDTH=8) -> result 0x10, C=1, Z=0, N=0, V=0; out_valid 1 cycle after accept. ADD 0x7F+0x01 -> 0x80, V=1, N=1.
- SUB a=0x50 b=0x70 -> result 0xE0, C=0, N=1, V=0. SUB 0x33-0x33 -> 0x00, Z=1, C=1.
- SHL a=0x81 b=3 -> result 0x08, C=0; out_valid 4 cycles after accept; busy=1 throughout. SRA a=0x80 b=200 -> result 0xFF, C=1, latency 9.
- Backpressure: ADD completes with out_ready held 0 for 5 cycles -> result and flags stable, in_ready=0 and in_valid ignored; the result is released on the first out_ready=1 cycle, then in_ready=1 on the next cycle.
- Reset mid-operation: SHR a=0xFF b=7, pull rst_n low at the 3rd EXEC cycle -> all outputs 0 immediately; after release in_ready=1 and a new ADD 0x01+0x01 returns 0x02.
- op=1000 a=0x0F b=0x11: with ALU_MUL_EN -> result 0xFF, C=0, latency 9. Same product 0x10*0x10 -> 0x00, Z=1, C=1. Without the macro -> result 0x00, err=1, latency 1.
